adc_channel_sequencer: RTL
==========================

Name: adc_channel_sequencer

Overview:
- Controller for the LTC2308 ADC interface block: drives its start/channel inputs and collects its ready/data outputs.
- Round-robin scans a mask of single-ended channels 0..7.
- Compensates the one-frame config pipeline: config shifted out during frame k selects the conversion read out at the end of frame k+1.
- Delivers channel-tagged samples through a small FIFO with a valid/ready handshake to downstream (UART / F2H bridge).

Parameters:
FIFO_DEPTH, 4, sample FIFO entries; power of 2, >=2
OVR_W, 8, width of saturating overrun counter

Ports:
clock  in  1  ADC interface clock (40MHz); all logic on posedge
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = scan mask continuously
channel_mask  in  8  bit i enables single-ended channel i
adc_start  out  1  to ADC block start
adc_channel  out  4  to ADC block channel; always 0..7 (bit3 = 0)
adc_ready  in  1  one-clock ADC sample-ready pulse
adc_data  in  12  ADC sample, valid with adc_ready
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accepts head
out_channel  out  3  channel tag of head
out_data  out  12  sample of head
overrun_count  out  OVR_W  samples dropped because FIFO full; saturates
busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high): state IDLE, adc_start=0, adc_channel=0, pending_ch=0, FIFO empty, out_valid=0, out_channel=0, out_data=0, overrun_count=0.
- nxt(c, m): lowest set bit of m with index > c; if none, wrap to the lowest set bit of m.
- Stop condition: enable=0 or channel_mask=0.
- IDLE:
  - If stop condition false: adc_channel <= lowest set bit of mask, adc_start <= 1, go to PRIME. Both registered in the same cycle, so channel is stable before the ADC config window.
  - Otherwise stay in IDLE.
- PRIME: wait for adc_ready.
  - This first sample belongs to a stale config: discard it, never push it.
  - On adc_ready: pending_ch <= adc_channel; adc_channel <= nxt(adc_channel, mask); go to RUN.
  - If the stop condition occurs on that pulse: adc_start <= 0, go to IDLE.
- RUN, on adc_ready:
  - Push {pending_ch[2:0], adc_data}.
  - pending_ch <= adc_channel; adc_channel <= nxt(adc_channel, mask sampled this cycle).
  - If stop condition: adc_start <= 0, go to IDLE. The sample is still pushed; the in-flight config is abandoned.
- Stop is honoured only on an adc_ready cycle, so the ADC completes its current frame and halts cleanly at end of frame.
- Re-enable before the ADC has halted is legal: PRIME discards the first sample.
- adc_channel changes only in the cycle after adc_ready (or on leaving IDLE), never inside the ADC config window.
- Mask changes take effect at the next adc_ready. The sample already in flight keeps its original tag.
- FIFO: first-word-fall-through; out_* reflect the head.
  - Head is held stable while out_valid && !out_ready.
  - Pop when out_valid && out_ready.
  - Push when full and no pop in the same cycle: drop the sample; overrun_count +1, saturating at all-ones.
  - Push while full with a simultaneous pop: accept; count unchanged.
  - Push into empty: out_valid=1 the next cycle (latency 1 clock from adc_ready).
- overrun_count clears only on reset.

Optional Feature:
ADC_SEQ_TIMESTAMP_EN
- Defined:
  - Adds port out_timestamp (out, 16): frame counter value captured at push, carried through the FIFO (entry widens to 31 bits).
  - The counter increments on every adc_ready, including discarded ones, wraps at 16 bits, and clears on leaving IDLE and on reset.
  - Gaps in out_timestamp reveal dropped samples.
- Undefined: no port, no counter, 15-bit FIFO entries.

Test Plan:
1. mask=0x05, enable=1, ADC model returns 0x100+channel of the config applied -> first ready discarded; outputs (ch0,0x100),(ch2,0x102),(ch0,0x100)...; adc_channel sequence 0,2,0,2.
2. mask=0x80 -> adc_channel constant 7; every output ch7 after the priming frame; no adc_channel toggle.
3. FIFO_DEPTH=4, out_ready=0 for 10 post-prime frames -> out_valid=1, 4 entries retained in order, overrun_count=6; then out_ready=1 drains exactly those 4. A further case with overrun exceeding 255 saturates at 0xFF.
4. enable dropped mid-frame in RUN -> next adc_ready sample still pushed, adc_start=0 the following cycle, busy=0; re-enable after 3 cycles -> PRIME discards the next ready.
5. mask 0x03->0x0C applied between readies, adc_channel=1 -> next adc_channel=2, then 3,2; one trailing ch0 or ch1 sample is tagged correctly.
6. reset asserted mid-RUN with FIFO holding 2 entries -> same cycle: out_valid=0, adc_start=0, overrun_count=0, busy=0.

Source files
------------

// File: rtl/adc_channel_sequencer.sv
// Round-robin channel sequencer for an LTC2308 interface block, delivering channel-tagged samples
// through a first-word-fall-through FIFO. Define ADC_SEQ_TIMESTAMP_EN to add out_timestamp.
module adc_channel_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned OVR_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [7:0]       channel_mask,
    output logic             adc_start,
    output logic [3:0]       adc_channel,
    input  logic             adc_ready,
    input  logic [11:0]      adc_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_channel,
    output logic [11:0]      out_data,
`ifdef ADC_SEQ_TIMESTAMP_EN
    output logic [15:0]      out_timestamp,
`endif
    output logic [OVR_W-1:0] overrun_count,
    output logic             busy
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
`ifdef ADC_SEQ_TIMESTAMP_EN
    localparam int unsigned EntryW = 31;
`else
    localparam int unsigned EntryW = 15;
`endif

    typedef enum logic [1:0] {StIdle, StPrime, StRun} state_t;

    state_t            state;
    logic [2:0]        chan_q;
    logic [2:0]        pending_ch;
    logic              stop;

    logic [EntryW-1:0] mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_q;
    logic [PtrW-1:0]   rd_q;
    logic [CntW-1:0]   count_q;
    logic [OVR_W-1:0]  ovr_q;
    logic              push;
    logic              pop;
    logic              full;
    logic              accept;
    logic              drop;
    logic [EntryW-1:0] push_entry;
    logic [EntryW-1:0] head;

    // Lowest set bit of m above c, wrapping to the lowest set bit; c = 7 yields the lowest.
    function automatic logic [2:0] next_ch(input logic [2:0] c, input logic [7:0] m);
        logic [2:0] lo;
        logic [2:0] hi;
        logic       hi_found;
        lo       = 3'd0;
        hi       = 3'd0;
        hi_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                lo = 3'(i);
                if (i > int'(c)) begin
                    hi       = 3'(i);
                    hi_found = 1'b1;
                end
            end
        end
        return hi_found ? hi : lo;
    endfunction

    assign stop        = !enable || (channel_mask == 8'h00);
    assign adc_channel = {1'b0, chan_q};
    assign busy        = (state != StIdle);

    // Channel only moves on leaving idle or right after a ready pulse, never mid config window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            adc_start  <= 1'b0;
            chan_q     <= 3'd0;
            pending_ch <= 3'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (!stop) begin
                        chan_q    <= next_ch(3'd7, channel_mask);
                        adc_start <= 1'b1;
                        state     <= StPrime;
                    end
                end
                StPrime, StRun: begin
                    if (adc_ready) begin
                        pending_ch <= chan_q;
                        chan_q     <= next_ch(chan_q, channel_mask);
                        if (stop) begin
                            adc_start <= 1'b0;
                            state     <= StIdle;
                        end else begin
                            state <= StRun;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef ADC_SEQ_TIMESTAMP_EN
    logic [15:0] frame_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_q <= 16'd0;
        end else if (state == StIdle && !stop) begin
            frame_q <= 16'd0;
        end else if (adc_ready) begin
            frame_q <= frame_q + 16'd1;
        end
    end

    assign push_entry    = {frame_q, pending_ch, adc_data};
    assign out_timestamp = out_valid ? head[30:15] : 16'd0;
`else
    assign push_entry = {pending_ch, adc_data};
`endif

    // The priming sample belongs to a stale config and is never queued.
    assign push      = (state == StRun) && adc_ready;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (count_q == CntW'(FIFO_DEPTH));
    assign accept    = push && (!full || pop);
    assign drop      = push && full && !pop;

    assign head        = mem[rd_q];
    assign out_channel = out_valid ? head[14:12] : 3'd0;
    assign out_data    = out_valid ? head[11:0] : 12'd0;
    assign overrun_count = ovr_q;

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_q] <= push_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovr_q   <= '0;
        end else begin
            if (accept) begin
                wr_q <= wr_q + PtrW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PtrW'(1);
            end
            unique case ({accept, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            if (drop && (ovr_q != '1)) begin
                ovr_q <= ovr_q + OVR_W'(1);
            end
        end
    end

endmodule
